// File: rtl/write_data_resp_slave.sv
// Write-only AXI-Lite style slave: independent AW/W capture, register-file update, buffered B response.
// Build macro WRITE_PROT_CHECK_EN rejects unprivileged (AWPROT[0]==0) writes to register 0.
module write_data_resp_slave #(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic [2:0]  AWPROT,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
  input  logic [3:0]  rd_idx,
  output logic [31:0] rd_data
);

  localparam int          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] SPAN       = 32'(4 * NUM_REGS);
  localparam logic [4:0]  NUM_REGS_L = 5'(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HAVE_ADDR = 3'd1,
    HAVE_DATA = 3'd2,
    WRITE     = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t      state_r;
  logic        awready_r;
  logic        wready_r;
  logic        bvalid_r;
  logic [1:0]  bresp_r;
  logic [31:0] addr_r;
  logic [2:0]  prot_r;
  logic [31:0] data_r;
  logic [3:0]  strb_r;
  logic [31:0] regs_r [NUM_REGS];

  logic             aw_hs_s;
  logic             w_hs_s;
  logic [31:0]      offset_s;
  logic [IDX_W-1:0] idx_s;
  logic             access_ok_s;
  logic             unused_s;

  // Handshake detection and decode of the latched address (modulo-2^32 offset).
  always_comb begin
    aw_hs_s  = AWVALID & awready_r;
    w_hs_s   = WVALID & wready_r;
    offset_s = addr_r - BASE_ADDR;
    idx_s    = offset_s[IDX_W+1:2];
`ifdef WRITE_PROT_CHECK_EN
    access_ok_s = (offset_s < SPAN) && (offset_s[1:0] == 2'b00) &&
                  !((offset_s[31:2] == 30'd0) && (prot_r[0] == 1'b0));
`else
    access_ok_s = (offset_s < SPAN) && (offset_s[1:0] == 2'b00);
`endif
    unused_s = ^prot_r;
  end

  // Transaction FSM; ready/response outputs are registered from the next state.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_r   <= IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      addr_r    <= 32'h0000_0000;
      prot_r    <= 3'b000;
      data_r    <= 32'h0000_0000;
      strb_r    <= 4'b0000;
    end else begin
      if (aw_hs_s) begin
        addr_r <= AWADDR;
        prot_r <= AWPROT;
      end
      if (w_hs_s) begin
        data_r <= WDATA;
        strb_r <= WSTRB;
      end
      case (state_r)
        IDLE: begin
          if (aw_hs_s && w_hs_s) begin
            state_r   <= WRITE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
          end else if (aw_hs_s) begin
            state_r   <= HAVE_ADDR;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
          end else if (w_hs_s) begin
            state_r   <= HAVE_DATA;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
          end else begin
            // Also raises both readies in the first cycle after reset release.
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        HAVE_ADDR: begin
          if (w_hs_s) begin
            state_r  <= WRITE;
            wready_r <= 1'b0;
          end
        end
        HAVE_DATA: begin
          if (aw_hs_s) begin
            state_r   <= WRITE;
            awready_r <= 1'b0;
          end
        end
        WRITE: begin
          state_r  <= RESP;
          bvalid_r <= 1'b1;
          bresp_r  <= access_ok_s ? 2'b00 : 2'b10;
        end
        RESP: begin
          if (BREADY) begin
            state_r   <= IDLE;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
          bresp_r   <= 2'b00;
        end
      endcase
    end
  end

  // Register file: byte-lane update at the end of a valid WRITE cycle.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if ((state_r == WRITE) && access_ok_s) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_r[b]) begin
          regs_r[idx_s][8*b +: 8] <= data_r[8*b +: 8];
        end
      end
    end
  end

  // Combinational readback; out-of-range indices read as zero.
  always_comb begin
    if ({1'b0, rd_idx} < NUM_REGS_L) begin
      rd_data = regs_r[rd_idx[IDX_W-1:0]];
    end else begin
      rd_data = 32'h0000_0000;
    end
  end

  assign AWREADY = awready_r;
  assign WREADY  = wready_r;
  assign BVALID  = bvalid_r;
  assign BRESP   = bresp_r;

endmodule

// File: tb/tb_write_data_resp_slave.sv
// Directed bench for write_data_resp_slave with a transaction-level register model checked every cycle.
module tb_write_data_resp_slave;

  localparam int          NREGS = 8;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] AWADDR, WDATA, rd_data;
  logic [2:0]  AWPROT;
  logic [3:0]  WSTRB, rd_idx;
  logic [1:0]  BRESP;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] exp_regs [NREGS];
  logic [1:0]  exp_resp;
  logic        prev_bvalid;

  write_data_resp_slave #(.NUM_REGS(NREGS), .BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Register model: a write lands only if it hits an aligned word inside the window.
  task automatic model_apply(input txn_t t, output logic [1:0] resp);
    logic [31:0] off;
    int idx;
    off  = t.addr - BASE;
    idx  = int'(off >> 2);
    resp = 2'b00;
    if (off >= 32'(4 * NREGS) || off[1:0] != 2'b00) resp = 2'b10;
`ifdef WRITE_PROT_CHECK_EN
    else if (idx == 0 && t.prot[0] == 1'b0) resp = 2'b10;
`endif
    if (resp == 2'b00) begin
      for (int b = 0; b < 4; b++) begin
        if (t.strb[b]) exp_regs[idx][8*b +: 8] = t.data[8*b +: 8];
      end
    end
  endtask

  // Per-cycle compare of readback and response against the model.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      exp_q.delete();
      for (int i = 0; i < NREGS; i++) exp_regs[i] = 32'h0;
      exp_resp    = 2'b00;
      prev_bvalid = 1'b0;
    end else begin
      if (BVALID && !prev_bvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bvalid", 32'(BVALID), 32'h0);
        end else begin
          model_apply(exp_q.pop_front(), exp_resp);
        end
      end
      chk("model_bresp", 32'(BRESP), BVALID ? 32'(exp_resp) : 32'h0);
      chk("model_rd_data", rd_data, (int'(rd_idx) < NREGS) ? exp_regs[rd_idx] : 32'h0);
      prev_bvalid = BVALID;
    end
  end

  task automatic push(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d, input logic [3:0] s);
    txn_t t;
    t.addr = a; t.prot = p; t.data = d; t.strb = s;
    exp_q.push_back(t);
  endtask

  task automatic send_both(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d, input logic [3:0] s);
    logic ok = 1'b0;
    AWADDR = a; AWPROT = p; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (AWREADY && WREADY) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge ACLK); #1; end
    else chk("both_timeout", 32'(ok), 32'h1);
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [2:0] p);
    logic ok = 1'b0;
    AWADDR = a; AWPROT = p; AWVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (AWREADY) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge ACLK); #1; end
    else chk("aw_timeout", 32'(ok), 32'h1);
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    logic ok = 1'b0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (WREADY) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge ACLK); #1; end
    else chk("w_timeout", 32'(ok), 32'h1);
    WVALID = 1'b0;
  endtask

  // Waits for BVALID, holds BREADY low for 'hold' cycles, then accepts.
  task automatic wait_resp(input int hold, output logic [1:0] resp, output int n);
    logic got = 1'b0;
    n = 0;
    resp = 2'bxx;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      if (BVALID) begin got = 1'b1; n = i + 1; break; end
    end
    if (!got) begin
      chk("bvalid_timeout", 32'(got), 32'h1);
    end else begin
      resp = BRESP;
      for (int k = 0; k < hold; k++) begin
        chk("hold_bvalid", 32'(BVALID), 32'h1);
        chk("hold_bresp", 32'(BRESP), 32'(resp));
        chk("hold_readys", {30'h0, AWREADY, WREADY}, 32'h0);
        @(negedge ACLK);
      end
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      chk("after_resp_readys", {30'h0, AWREADY, WREADY}, 32'h3);
      chk("after_resp_bvalid", 32'(BVALID), 32'h0);
    end
  endtask

  task automatic peek(input logic [3:0] idx, input logic [31:0] req, input string name);
    rd_idx = idx;
    @(negedge ACLK);
    chk(name, rd_data, req);
    @(posedge ACLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    int n;
    ARESETn = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    AWADDR = 32'h0; AWPROT = 3'b000; WDATA = 32'h0; WSTRB = 4'h0; rd_idx = 4'h0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_readys", {30'h0, AWREADY, WREADY}, 32'h0);
    chk("reset_bvalid", 32'(BVALID), 32'h0);
    chk("reset_bresp", 32'(BRESP), 32'h0);
    chk("reset_reg0", rd_data, 32'h0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("release_readys", {30'h0, AWREADY, WREADY}, 32'h3);

    // Simultaneous AW/W: response two cycles after acceptance.
    push(32'h4, 3'b000, 32'hDEADBEEF, 4'hF);
    send_both(32'h4, 3'b000, 32'hDEADBEEF, 4'hF);
    wait_resp(0, resp, n);
    chk("simul_latency", 32'(n), 32'h2);
    chk("simul_bresp", 32'(resp), 32'h0);
    peek(4'd1, 32'hDEADBEEF, "simul_reg1");

    // W first, AW three cycles later; a second W offered meanwhile must be stalled.
    push(32'h8, 3'b000, 32'h11223344, 4'b0101);
    send_w(32'h11223344, 4'b0101);
    WDATA = 32'hBAD0BAD0; WSTRB = 4'hF; WVALID = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin AWADDR = 32'h8; AWPROT = 3'b000; AWVALID = 1'b1; end
      @(negedge ACLK);
      chk("wfirst_readys", {30'h0, AWREADY, WREADY}, 32'h2);
      @(posedge ACLK); #1;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_resp(0, resp, n);
    chk("wfirst_bresp", 32'(resp), 32'h0);
    peek(4'd2, 32'h00220044, "wfirst_reg2");

    // Partial strobe and empty strobe.
    push(32'h4, 3'b000, 32'h000000A5, 4'b0001);
    send_both(32'h4, 3'b000, 32'h000000A5, 4'b0001);
    wait_resp(0, resp, n);
    peek(4'd1, 32'hDEADBEA5, "strb1_reg1");
    push(32'hC, 3'b000, 32'hFFFFFFFF, 4'b0000);
    send_both(32'hC, 3'b000, 32'hFFFFFFFF, 4'b0000);
    wait_resp(0, resp, n);
    chk("strb0_bresp", 32'(resp), 32'h0);
    peek(4'd3, 32'h0, "strb0_reg3");

    // Out of range, then misaligned via the AW-before-W path.
    push(32'h20, 3'b000, 32'h55555555, 4'hF);
    send_both(32'h20, 3'b000, 32'h55555555, 4'hF);
    wait_resp(0, resp, n);
    chk("oor_bresp", 32'(resp), 32'h2);
    push(32'h6, 3'b000, 32'h66666666, 4'hF);
    send_aw(32'h6, 3'b000);
    send_w(32'h66666666, 4'hF);
    wait_resp(0, resp, n);
    chk("misal_bresp", 32'(resp), 32'h2);
    peek(4'd1, 32'hDEADBEA5, "invalid_reg1");

    // Response backpressure for five cycles.
    push(32'h10, 3'b000, 32'h12345678, 4'hF);
    send_both(32'h10, 3'b000, 32'h12345678, 4'hF);
    wait_resp(5, resp, n);
    chk("bp_bresp", 32'(resp), 32'h0);
    peek(4'd4, 32'h12345678, "bp_reg4");

    // Unprivileged then privileged write to register 0.
    push(32'h0, 3'b000, 32'h5, 4'hF);
    send_both(32'h0, 3'b000, 32'h5, 4'hF);
    wait_resp(0, resp, n);
`ifdef WRITE_PROT_CHECK_EN
    chk("prot0_bresp", 32'(resp), 32'h2);
    peek(4'd0, 32'h0, "prot0_reg0");
`else
    chk("prot0_bresp", 32'(resp), 32'h0);
    peek(4'd0, 32'h5, "prot0_reg0");
`endif
    push(32'h0, 3'b001, 32'h5, 4'hF);
    send_both(32'h0, 3'b001, 32'h5, 4'hF);
    wait_resp(0, resp, n);
    chk("prot1_bresp", 32'(resp), 32'h0);
    peek(4'd0, 32'h5, "prot1_reg0");

    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      @(posedge ACLK); #1;
    end

    // Reset during WRITE aborts the write and the response.
    push(32'h0, 3'b001, 32'hFFFFFFFF, 4'hF);
    send_both(32'h0, 3'b001, 32'hFFFFFFFF, 4'hF);
    ARESETn = 1'b0;
    @(negedge ACLK);
    chk("rstw_bvalid_a", 32'(BVALID), 32'h0);
    @(posedge ACLK); #1;
    chk("rstw_bvalid_b", 32'(BVALID), 32'h0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("rstw_readys", {30'h0, AWREADY, WREADY}, 32'h3);
    chk("rstw_bvalid_c", 32'(BVALID), 32'h0);
    peek(4'd0, 32'h0, "rstw_reg0");

    push(32'h1C, 3'b000, 32'hCAFEF00D, 4'hF);
    send_both(32'h1C, 3'b000, 32'hCAFEF00D, 4'hF);
    wait_resp(0, resp, n);
    chk("post_rst_bresp", 32'(resp), 32'h0);
    peek(4'd7, 32'hCAFEF00D, "post_rst_reg7");
    peek(4'd9, 32'h0, "rd_idx_oor");

    repeat (2) @(posedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
